// File: rtl/pmips_regfile_sb.sv
// Parametrised register file: zero register, two registered read ports with optional
// write-first bypass, one write port and a per-register busy scoreboard.
module pmips_regfile_sb #(
   parameter int unsigned n      = 8,
   parameter int unsigned NREG   = 32,
   parameter int unsigned AW     = $clog2(NREG),
   parameter int unsigned BYPASS = 1
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic          w,
   input  logic [AW-1:0] Waddr,
   input  logic [n-1:0]  Wdata,
   input  logic [AW-1:0] Raddr1,
   input  logic [AW-1:0] Raddr2,
   output logic [n-1:0]  Rdata1,
   output logic [n-1:0]  Rdata2,
   input  logic          lock,
   input  logic [AW-1:0] Laddr,
   output logic          Busy1,
   output logic          Busy2,
   output logic          BusyAny
);

   localparam int unsigned DEPTH = 2**AW;

   // register 0 is never stored; it is a constant in the read-source table
   logic [NREG-1:1][n-1:0]  regs_q, regs_d;
   logic [NREG-1:1]         busy_q, busy_d;
   logic [DEPTH-1:0][n-1:0] rd_src;
   logic [DEPTH-1:0]        busy_src;

   for (genvar i = 1; i < NREG; i++) begin : g_reg
      logic wsel;
      logic lsel;
      assign wsel       = w    && (Waddr == AW'(i));
      assign lsel       = lock && (Laddr == AW'(i));
      assign regs_d[i]  = wsel ? Wdata : regs_q[i];
      // a lock in the same cycle as the writeback names a newer producer, so set wins
      assign busy_d[i]  = lsel | (busy_q[i] & ~wsel);
   end

   // full 2**AW table so that zero and out-of-range addresses read as 0
   for (genvar i = 0; i < DEPTH; i++) begin : g_src
      if (i == 0 || i >= NREG) begin : g_zero
         assign rd_src[i]   = '0;
         assign busy_src[i] = 1'b0;
      end else if (BYPASS != 0) begin : g_wf
         assign rd_src[i]   = regs_d[i];
         assign busy_src[i] = busy_d[i];
      end else begin : g_rf
         assign rd_src[i]   = regs_q[i];
         assign busy_src[i] = busy_q[i];
      end
   end

   // storage, scoreboard and registered read outputs
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         regs_q  <= '0;
         busy_q  <= '0;
         Rdata1  <= '0;
         Rdata2  <= '0;
         Busy1   <= 1'b0;
         Busy2   <= 1'b0;
         BusyAny <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         Rdata1  <= rd_src[Raddr1];
         Rdata2  <= rd_src[Raddr2];
         Busy1   <= busy_src[Raddr1];
         Busy2   <= busy_src[Raddr2];
         BusyAny <= |busy_d;
      end
   end

endmodule

// File: tb/tb_pmips_regfile_sb.sv
// Bench for pmips_regfile_sb: three instances (write-first/32, read-first/32,
// write-first/20) share one stimulus stream and are checked against a reference model.
module tb_pmips_regfile_sb;

   localparam int unsigned N  = 8;
   localparam int unsigned AW = 5;

   logic          clk    = 1'b0;
   logic          nReset = 1'b0;
   logic          w      = 1'b0;
   logic          lock   = 1'b0;
   logic [AW-1:0] Waddr  = '0;
   logic [AW-1:0] Raddr1 = '0;
   logic [AW-1:0] Raddr2 = '0;
   logic [AW-1:0] Laddr  = '0;
   logic [N-1:0]  Wdata  = '0;

   logic [N-1:0] rd1 [3];
   logic [N-1:0] rd2 [3];
   logic         b1  [3];
   logic         b2  [3];
   logic         ba  [3];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pmips_regfile_sb #(.n(8), .NREG(32), .BYPASS(1)) dut_wf (
      .clk(clk), .nReset(nReset), .w(w), .Waddr(Waddr), .Wdata(Wdata),
      .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1[0]), .Rdata2(rd2[0]),
      .lock(lock), .Laddr(Laddr), .Busy1(b1[0]), .Busy2(b2[0]), .BusyAny(ba[0]));

   pmips_regfile_sb #(.n(8), .NREG(32), .BYPASS(0)) dut_rf (
      .clk(clk), .nReset(nReset), .w(w), .Waddr(Waddr), .Wdata(Wdata),
      .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1[1]), .Rdata2(rd2[1]),
      .lock(lock), .Laddr(Laddr), .Busy1(b1[1]), .Busy2(b2[1]), .BusyAny(ba[1]));

   pmips_regfile_sb #(.n(8), .NREG(20), .BYPASS(1)) dut_nr (
      .clk(clk), .nReset(nReset), .w(w), .Waddr(Waddr), .Wdata(Wdata),
      .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1[2]), .Rdata2(rd2[2]),
      .lock(lock), .Laddr(Laddr), .Busy1(b1[2]), .Busy2(b2[2]), .BusyAny(ba[2]));

   // ---------------- reference model ----------------
   logic [N-1:0] m_mem  [3][32];
   logic         m_busy [3][32];
   logic [N-1:0] e_rd1 [3];
   logic [N-1:0] e_rd2 [3];
   logic         e_b1  [3];
   logic         e_b2  [3];
   logic         e_ba  [3];

   function automatic int unsigned nreg_of(int k);
      return (k == 2) ? 20 : 32;
   endfunction

   function automatic bit byp_of(int k);
      return k != 1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 32; a++) begin
            m_mem[k][a]  = '0;
            m_busy[k][a] = 1'b0;
         end
         e_rd1[k] = '0; e_rd2[k] = '0;
         e_b1[k]  = 1'b0; e_b2[k] = 1'b0; e_ba[k] = 1'b0;
      end
   endtask

   // Apply one rising edge's worth of rules to the model using the current inputs.
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         logic [N-1:0] nm [32];
         logic         nb [32];
         int unsigned  nr;
         bit           any;
         nr  = nreg_of(k);
         any = 1'b0;
         for (int a = 0; a < 32; a++) begin
            nm[a] = m_mem[k][a];
            nb[a] = m_busy[k][a];
         end
         if (w && Waddr != 0 && 32'(Waddr) < nr) begin
            nm[Waddr] = Wdata;
            nb[Waddr] = 1'b0;
         end
         if (lock && Laddr != 0 && 32'(Laddr) < nr)
            nb[Laddr] = 1'b1;
         if (Raddr1 == 0 || 32'(Raddr1) >= nr) begin
            e_rd1[k] = '0; e_b1[k] = 1'b0;
         end else if (byp_of(k)) begin
            e_rd1[k] = nm[Raddr1]; e_b1[k] = nb[Raddr1];
         end else begin
            e_rd1[k] = m_mem[k][Raddr1]; e_b1[k] = m_busy[k][Raddr1];
         end
         if (Raddr2 == 0 || 32'(Raddr2) >= nr) begin
            e_rd2[k] = '0; e_b2[k] = 1'b0;
         end else if (byp_of(k)) begin
            e_rd2[k] = nm[Raddr2]; e_b2[k] = nb[Raddr2];
         end else begin
            e_rd2[k] = m_mem[k][Raddr2]; e_b2[k] = m_busy[k][Raddr2];
         end
         for (int a = 0; a < 32; a++) begin
            any          = any | nb[a];
            m_mem[k][a]  = nm[a];
            m_busy[k][a] = nb[a];
         end
         e_ba[k] = any;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_model(string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s dut%0d Rdata1", tag, k), 32'(rd1[k]), 32'(e_rd1[k]));
         chk($sformatf("%s dut%0d Rdata2", tag, k), 32'(rd2[k]), 32'(e_rd2[k]));
         chk($sformatf("%s dut%0d Busy1", tag, k),  32'(b1[k]),  32'(e_b1[k]));
         chk($sformatf("%s dut%0d Busy2", tag, k),  32'(b2[k]),  32'(e_b2[k]));
         chk($sformatf("%s dut%0d BusyAny", tag, k), 32'(ba[k]), 32'(e_ba[k]));
      end
   endtask

   task automatic step(string tag);
      model_edge();
      @(posedge clk);
      #1;
      chk_model(tag);
   endtask

   task automatic set_in(logic iw, logic [4:0] wa, logic [7:0] wd,
                         logic [4:0] r1, logic [4:0] r2, logic lk, logic [4:0] la);
      w = iw; Waddr = wa; Wdata = wd; Raddr1 = r1; Raddr2 = r2; lock = lk; Laddr = la;
   endtask

   // Directed vectors; expectations are for the write-first/32 instance plus
   // Rdata1 of the read-first/32 instance (x_rf1).
   typedef struct {
      logic       w;
      logic [4:0] wa;
      logic [7:0] wd;
      logic [4:0] r1;
      logic [4:0] r2;
      logic       lk;
      logic [4:0] la;
      logic [7:0] x_r1;
      logic [7:0] x_r2;
      logic       x_b1;
      logic       x_b2;
      logic       x_ba;
      logic [7:0] x_rf1;
   } vec_t;

   vec_t tbl [13];

   initial begin
      tbl[0]  = '{1'b1, 5'd0,  8'hFF, 5'd0,  5'd0, 1'b0, 5'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 5'd1,  8'h0B, 5'd0,  5'd0, 1'b0, 5'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 5'd2,  8'hAF, 5'd1,  5'd3, 1'b0, 5'd0,  8'h0B, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0B};
      tbl[3]  = '{1'b0, 5'd0,  8'h00, 5'd1,  5'd2, 1'b0, 5'd0,  8'h0B, 8'hAF, 1'b0, 1'b0, 1'b0, 8'h0B};
      tbl[4]  = '{1'b0, 5'd0,  8'h00, 5'd2,  5'd1, 1'b0, 5'd0,  8'hAF, 8'h0B, 1'b0, 1'b0, 1'b0, 8'hAF};
      tbl[5]  = '{1'b1, 5'd1,  8'hFF, 5'd1,  5'd1, 1'b0, 5'd0,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h0B};
      tbl[6]  = '{1'b0, 5'd0,  8'h00, 5'd1,  5'd1, 1'b0, 5'd0,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
      tbl[7]  = '{1'b0, 5'd0,  8'h00, 5'd5,  5'd0, 1'b1, 5'd5,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[8]  = '{1'b0, 5'd0,  8'h00, 5'd5,  5'd0, 1'b0, 5'd0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[9]  = '{1'b1, 5'd5,  8'h03, 5'd5,  5'd0, 1'b0, 5'd0,  8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[10] = '{1'b1, 5'd5,  8'h07, 5'd5,  5'd0, 1'b1, 5'd5,  8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03};
      tbl[11] = '{1'b1, 5'd6,  8'h44, 5'd6,  5'd7, 1'b1, 5'd7,  8'h44, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
      tbl[12] = '{1'b1, 5'd25, 8'h5A, 5'd25, 5'd5, 1'b1, 5'd25, 8'h5A, 8'h07, 1'b1, 1'b1, 1'b1, 8'h00};

      // reset state while nReset is held low
      model_reset();
      #12;
      chk_model("reset");
      @(posedge clk);
      #1;
      nReset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2, tbl[i].lk, tbl[i].la);
         step($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d wf Rdata1", i),  32'(rd1[0]), 32'(tbl[i].x_r1));
         chk($sformatf("tbl%0d wf Rdata2", i),  32'(rd2[0]), 32'(tbl[i].x_r2));
         chk($sformatf("tbl%0d wf Busy1", i),   32'(b1[0]),  32'(tbl[i].x_b1));
         chk($sformatf("tbl%0d wf Busy2", i),   32'(b2[0]),  32'(tbl[i].x_b2));
         chk($sformatf("tbl%0d wf BusyAny", i), 32'(ba[0]),  32'(tbl[i].x_ba));
         chk($sformatf("tbl%0d rf Rdata1", i),  32'(rd1[1]), 32'(tbl[i].x_rf1));
      end

      // asynchronous reset pulse in the middle of a write to reg3, busy[7] set
      set_in(1'b1, 5'd3, 8'hCC, 5'd3, 5'd7, 1'b0, 5'd0);
      #2;
      nReset = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("async rst dut%0d Rdata1", k), 32'(rd1[k]), 32'd0);
         chk($sformatf("async rst dut%0d Rdata2", k), 32'(rd2[k]), 32'd0);
         chk($sformatf("async rst dut%0d Busy1", k),  32'(b1[k]),  32'd0);
         chk($sformatf("async rst dut%0d Busy2", k),  32'(b2[k]),  32'd0);
         chk($sformatf("async rst dut%0d BusyAny", k), 32'(ba[k]), 32'd0);
      end
      @(posedge clk);
      #1;
      chk_model("rst held");
      nReset = 1'b1;
      w      = 1'b0;
      for (int i = 0; i < 32; i++) begin
         set_in(1'b0, 5'd0, 8'h00, 5'(i), 5'((i + 3) % 32), 1'b0, 5'd0);
         step($sformatf("post-rst r%0d", i));
         chk($sformatf("post-rst r%0d Rdata1", i), 32'(rd1[0]), 32'd0);
         chk($sformatf("post-rst r%0d BusyAny", i), 32'(ba[0]), 32'd0);
      end

      // out-of-range write / read / lock on the 20-register instance
      set_in(1'b1, 5'd25, 8'h5A, 5'd25, 5'd0, 1'b1, 5'd25);
      step("oor0");
      chk("oor0 nr Rdata1",  32'(rd1[2]), 32'd0);
      chk("oor0 nr BusyAny", 32'(ba[2]),  32'd0);
      chk("oor0 wf Rdata1",  32'(rd1[0]), 32'h5A);
      set_in(1'b0, 5'd0, 8'h00, 5'd25, 5'd0, 1'b0, 5'd0);
      step("oor1");
      chk("oor1 nr Rdata1",  32'(rd1[2]), 32'd0);
      chk("oor1 nr BusyAny", 32'(ba[2]),  32'd0);
      chk("oor1 wf Rdata1",  32'(rd1[0]), 32'h5A);
      chk("oor1 wf BusyAny", 32'(ba[0]),  32'd1);

      // randomized traffic, biased towards address collisions
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wa;
         wa     = 5'($urandom_range(0, 31));
         w      = 1'($urandom_range(0, 1));
         Waddr  = wa;
         Wdata  = 8'($urandom);
         Raddr1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
         Raddr2 = ($urandom_range(0, 2) == 0) ? Raddr1 : 5'($urandom_range(0, 31));
         lock   = ($urandom_range(0, 2) == 0);
         Laddr  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         step($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
